aead_ctrl_param: RTL and testbench

- Parametrised successor of the SpoC-128 control FSM. Sequences key load, nonce load, AD/PT/CT absorption, per-block permutations and tag generation or verification for a sponge AEAD datapath.
- Word counts and bus width are set by parameters. Per-word output byte enables and in-block tag comparison are new.
- Sits between the AEAD bdi/bdo/key handshakes and the permutation datapath.

---
 rtl/aead_ctrl_param.sv | 278 +++++++++++++++++++++++++++
 tb/tb_aead_ctrl_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aead_ctrl_param.sv
// rtl/aead_ctrl_param.sv - parametrised sponge AEAD control FSM
// Sequences key/nonce load, AD/data absorption, permutations and tag output/verification.
module aead_ctrl_param #(
  parameter int W          = 32,
  parameter int KEY_WORDS  = 4,
  parameter int NPUB_WORDS = 4,
  parameter int BLK_WORDS  = 4,
  parameter int TAG_WORDS  = 4,
  parameter int CW         = 3,
  localparam int NB        = W / 8,
  localparam int SW        = $clog2(NB) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_key_update,
  input  logic          i_key_valid,
  output logic          o_key_ready,
  input  logic          i_bdi_valid,
  output logic          o_bdi_ready,
  input  logic [3:0]    i_bdi_type,
  input  logic          i_bdi_eot,
  input  logic          i_bdi_eoi,
  input  logic [SW-1:0] i_bdi_size,
  input  logic          i_decrypt,
  input  logic          i_bdo_ready,
  output logic          o_bdo_valid,
  output logic [NB-1:0] o_bdo_valid_bytes,
  output logic          o_end_of_block,
  input  logic          i_msg_auth_ready,
  output logic          o_msg_auth_valid,
  output logic          o_msg_auth,
  input  logic          i_perm_done,
  input  logic          i_tag_match,
  output logic          o_perm_start,
  output logic          o_en_key,
  output logic          o_en_npub,
  output logic          o_en_bdi,
  output logic          o_clr_bdi,
  output logic          o_en_state,
  output logic          o_init_state,
  output logic          o_sel_tag,
  output logic [1:0]    o_ctrl_word,
  output logic [CW-1:0] o_word_idx,
  output logic          o_pad_blk
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_KEY, S_LD_NPUB, S_INIT, S_INIT_WAIT, S_ABSORB, S_PERM,
    S_OUT, S_PERM_WAIT, S_PRE_TAG, S_TAG_WAIT, S_OUT_TAG, S_LD_TAG, S_VERIFY
  } state_t;

  localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_WORDS - 1);
  localparam logic [CW-1:0] NPUB_LAST = CW'(NPUB_WORDS - 1);
  localparam logic [CW-1:0] BLK_LAST  = CW'(BLK_WORDS - 1);
  localparam logic [CW-1:0] TAG_LAST  = CW'(TAG_WORDS - 1);
  localparam logic [7:0]    FULL_BYTES = 8'(BLK_WORDS * NB);

  state_t                       r_state, w_next;
  logic [CW-1:0]                r_idx, w_idx_next;
  logic [CW-1:0]                r_last_idx;
  logic                         r_decrypt, r_eoi, r_eot, r_is_ad, r_fail;
  logic [7:0]                   r_accum;
  logic [BLK_WORDS-1:0][SW-1:0] r_sizes;
  logic [SW-1:0]                w_cur_size;
  logic                         w_pad;

  assign w_pad = (r_accum != FULL_BYTES) || (r_accum == 8'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx <= '0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx_next;
    end
  end

  // Block bookkeeping: flags are rebuilt at INIT so nothing leaks between messages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_idx <= '0;
      r_decrypt <= 1'b0;
      r_eoi <= 1'b0;
      r_eot <= 1'b0;
      r_is_ad <= 1'b0;
      r_fail <= 1'b0;
      r_accum <= 8'd0;
      r_sizes <= '0;
    end else begin
      case (r_state)
        S_LD_NPUB: begin
          if (i_bdi_valid && r_idx == NPUB_LAST) begin
            r_decrypt <= i_decrypt;
            r_eoi <= i_bdi_eoi & i_bdi_eot;
          end
        end
        S_INIT: begin
          r_accum <= 8'd0;
          r_fail <= 1'b0;
          r_eot <= 1'b0;
          r_is_ad <= 1'b0;
        end
        S_ABSORB: begin
          if (i_bdi_valid) begin
            r_accum <= r_accum + 8'(i_bdi_size);
            for (int i = 0; i < BLK_WORDS; i++) begin
              if (r_idx == CW'(i)) r_sizes[i] <= i_bdi_size;
            end
            r_is_ad <= (i_bdi_type == 4'b0001);
            r_eot <= i_bdi_eot;
            r_eoi <= i_bdi_eoi & i_bdi_eot;
            if (r_idx == BLK_LAST || i_bdi_eot) r_last_idx <= r_idx;
          end
        end
        S_PERM_WAIT: begin
          if (i_perm_done) r_accum <= 8'd0;
        end
        S_LD_TAG: begin
          if (i_bdi_valid) r_fail <= r_fail | ~i_tag_match;
        end
        S_VERIFY: begin
          if (i_msg_auth_ready) begin
            r_fail <= 1'b0;
            r_decrypt <= 1'b0;
            r_eoi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cur_size = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      if (r_idx == CW'(i)) w_cur_size = r_sizes[i];
    end
  end

  always_comb begin
    w_next = r_state;
    w_idx_next = r_idx;
    o_key_ready = 1'b0;
    o_bdi_ready = 1'b0;
    o_bdo_valid = 1'b0;
    o_bdo_valid_bytes = '1;
    o_end_of_block = 1'b0;
    o_msg_auth_valid = 1'b0;
    o_msg_auth = 1'b0;
    o_perm_start = 1'b0;
    o_en_key = 1'b0;
    o_en_npub = 1'b0;
    o_en_bdi = 1'b0;
    o_clr_bdi = 1'b0;
    o_en_state = 1'b0;
    o_init_state = 1'b0;
    o_sel_tag = 1'b0;
    o_ctrl_word = 2'b00;
    o_word_idx = r_idx;
    o_pad_blk = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_key_update && i_key_valid) w_next = S_LD_KEY;
        else if (i_bdi_valid) w_next = S_LD_NPUB;
      end
      S_LD_KEY: begin
        if (i_key_valid) begin
          o_key_ready = 1'b1;
          o_en_key = 1'b1;
          if (r_idx == KEY_LAST) begin
            w_idx_next = '0;
            w_next = S_LD_NPUB;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_LD_NPUB: begin
        if (i_bdi_valid) begin
          o_bdi_ready = 1'b1;
          o_en_npub = 1'b1;
          if (r_idx == NPUB_LAST) begin
            w_idx_next = '0;
            w_next = S_INIT;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_INIT: begin
        o_init_state = 1'b1;
        o_en_state = 1'b1;
        o_perm_start = 1'b1;
        w_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (i_perm_done) w_next = r_eoi ? S_PRE_TAG : S_ABSORB;
      end
      S_ABSORB: begin
        o_pad_blk = w_pad;
        if (i_bdi_valid) begin
          o_bdi_ready = 1'b1;
          o_en_bdi = 1'b1;
          if (r_idx == BLK_LAST || i_bdi_eot) begin
            w_idx_next = '0;
            w_next = S_PERM;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_PERM: begin
        o_pad_blk = w_pad;
        if (r_is_ad) begin
          o_ctrl_word = 2'b01;
          o_en_state = 1'b1;
          o_perm_start = 1'b1;
          w_next = S_PERM_WAIT;
        end else w_next = S_OUT;
      end
      S_OUT: begin
        o_pad_blk = w_pad;
        o_bdo_valid = 1'b1;
        o_bdo_valid_bytes = ~({NB{1'b1}} >> w_cur_size);
        o_end_of_block = (r_idx == r_last_idx) && r_eot;
        if (i_bdo_ready) begin
          if (r_idx == r_last_idx) begin
            w_idx_next = '0;
            // The final data block is absorbed by the tag permutation instead.
            if (!r_eoi) begin
              o_ctrl_word = 2'b10;
              o_en_state = 1'b1;
              o_perm_start = 1'b1;
              w_next = S_PERM_WAIT;
            end else w_next = S_PRE_TAG;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_PERM_WAIT: begin
        if (i_perm_done) begin
          o_clr_bdi = 1'b1;
          w_next = r_eoi ? S_PRE_TAG : S_ABSORB;
        end
      end
      S_PRE_TAG: begin
        o_en_state = 1'b1;
        o_perm_start = 1'b1;
        w_next = S_TAG_WAIT;
      end
      S_TAG_WAIT: begin
        if (i_perm_done) w_next = r_decrypt ? S_LD_TAG : S_OUT_TAG;
      end
      S_OUT_TAG: begin
        o_sel_tag = 1'b1;
        o_bdo_valid = 1'b1;
        o_end_of_block = (r_idx == TAG_LAST);
        if (i_bdo_ready) begin
          if (r_idx == TAG_LAST) begin
            w_idx_next = '0;
            w_next = S_IDLE;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_LD_TAG: begin
        if (i_bdi_valid) begin
          o_bdi_ready = 1'b1;
          o_en_bdi = 1'b1;
          if (r_idx == TAG_LAST) begin
            w_idx_next = '0;
            w_next = S_VERIFY;
          end else w_idx_next = r_idx + CW'(1);
        end
      end
      S_VERIFY: begin
        o_msg_auth_valid = 1'b1;
        o_msg_auth = ~r_fail;
        if (i_msg_auth_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aead_ctrl_param.sv
// tb/tb_aead_ctrl_param.sv - directed self-checking bench for aead_ctrl_param
module tb_aead_ctrl_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_update = 0, key_valid = 0, key_ready;
  logic       bdi_valid = 0, bdi_ready;
  logic [3:0] bdi_type = 4'b0000;
  logic       bdi_eot = 0, bdi_eoi = 0;
  logic [2:0] bdi_size = 3'd0;
  logic       decrypt = 0, bdo_ready = 0, bdo_valid;
  logic [3:0] bdo_valid_bytes;
  logic       end_of_block, msg_auth_ready = 0, msg_auth_valid, msg_auth;
  logic       perm_done = 0, tag_match = 0, perm_start;
  logic       en_key, en_npub, en_bdi, clr_bdi, en_state, init_state, sel_tag;
  logic [1:0] ctrl_word;
  logic [2:0] word_idx;
  logic       pad_blk;
  int         errors = 0;
  int         checks = 0;

  aead_ctrl_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_update(key_update), .i_key_valid(key_valid),
    .o_key_ready(key_ready), .i_bdi_valid(bdi_valid), .o_bdi_ready(bdi_ready),
    .i_bdi_type(bdi_type), .i_bdi_eot(bdi_eot), .i_bdi_eoi(bdi_eoi), .i_bdi_size(bdi_size),
    .i_decrypt(decrypt), .i_bdo_ready(bdo_ready), .o_bdo_valid(bdo_valid),
    .o_bdo_valid_bytes(bdo_valid_bytes), .o_end_of_block(end_of_block),
    .i_msg_auth_ready(msg_auth_ready), .o_msg_auth_valid(msg_auth_valid), .o_msg_auth(msg_auth),
    .i_perm_done(perm_done), .i_tag_match(tag_match), .o_perm_start(perm_start),
    .o_en_key(en_key), .o_en_npub(en_npub), .o_en_bdi(en_bdi), .o_clr_bdi(clr_bdi),
    .o_en_state(en_state), .o_init_state(init_state), .o_sel_tag(sel_tag),
    .o_ctrl_word(ctrl_word), .o_word_idx(word_idx), .o_pad_blk(pad_blk)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    perm_done = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_bytes", bdo_valid_bytes, 4'hF);
    chk("rst_outs", {key_ready, bdi_ready, bdo_valid, end_of_block, msg_auth_valid, msg_auth,
                     perm_start, en_key, en_npub, en_bdi, clr_bdi, en_state, init_state,
                     sel_tag, ctrl_word, word_idx, pad_blk}, 0);
  endtask

  task automatic load_key();
    int cnt = 0;
    step(); key_update = 1; key_valid = 1; #1;
    chk("idle_key_ready", key_ready, 0);
    for (int c = 0; c < 9; c++) begin
      step(); key_update = 0; key_valid = (c % 2 == 0); #1;
      if (en_key) begin
        chk("key_idx", word_idx, cnt);
        cnt++;
      end
    end
    key_valid = 0;
    chk("key_pulses", cnt, 4);
  endtask

  task automatic load_npub(input bit from_idle, input bit dec, input bit eoi);
    if (from_idle) begin
      step(); bdi_valid = 1; #1;
      chk("idle_bdi_ready", bdi_ready, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(); bdi_valid = 1; decrypt = dec;
      bdi_eot = (i == 3) && eoi; bdi_eoi = (i == 3) && eoi; #1;
      chk("npub_en", {bdi_ready, en_npub}, 2'b11);
      chk("npub_idx", word_idx, i);
    end
    step(); bdi_valid = 0; bdi_eot = 0; bdi_eoi = 0; decrypt = 0; #1;
    chk("init_start", {init_state, en_state, perm_start, bdi_ready}, 4'b1110);
    step(); perm_done = 1; #1;
    chk("init_wait", perm_start, 0);
  endtask

  task automatic absorb(input logic [3:0] typ, input int n, input logic [11:0] sizes,
                        input bit eoi, input bit exp_pad);
    for (int i = 0; i < n; i++) begin
      step(); bdi_valid = 1; bdi_type = typ; bdi_size = sizes[i*3 +: 3];
      bdi_eot = (i == n - 1); bdi_eoi = (i == n - 1) && eoi; #1;
      chk("abs_ready", {bdi_ready, en_bdi, perm_start}, 3'b110);
      chk("abs_idx", word_idx, i);
    end
    step(); bdi_valid = 0; bdi_eot = 0; bdi_eoi = 0; #1;
    chk("perm_pad", pad_blk, exp_pad);
    if (typ == 4'b0001) begin
      chk("perm_ad", {ctrl_word, en_state, perm_start}, 4'b0111);
      step(); perm_done = 1; #1;
      chk("clr_bdi", clr_bdi, 1);
    end else begin
      chk("perm_data", perm_start, 0);
    end
  endtask

  task automatic out_data(input int n, input logic [15:0] bytes);
    step(); bdo_ready = 0; #1;
    chk("out_hold", {bdo_valid, word_idx}, 4'b1000);
    for (int i = 0; i < n; i++) begin
      step(); bdo_ready = 1; #1;
      chk("out_valid", {bdo_valid, sel_tag}, 2'b10);
      chk("out_idx", word_idx, i);
      chk("out_bytes", bdo_valid_bytes, bytes[i*4 +: 4]);
      chk("out_eob", end_of_block, i == n - 1);
      chk("out_start", perm_start, 0);
    end
  endtask

  task automatic tag_phase(input bit dec, input int mis, input bit exp_auth);
    step(); bdo_ready = 0; #1;
    chk("pretag", {en_state, perm_start, bdo_valid}, 3'b110);
    step(); perm_done = 1; #1;
    chk("tag_wait", perm_start, 0);
    if (!dec) begin
      for (int i = 0; i < 4; i++) begin
        step(); bdo_ready = 1; #1;
        chk("tag_sel", {sel_tag, bdo_valid, bdo_valid_bytes}, 6'b111111);
        chk("tag_idx", word_idx, i);
        chk("tag_eob", end_of_block, i == 3);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        step(); bdi_valid = 1; tag_match = (i != mis); #1;
        chk("tagin_ready", {bdi_ready, en_bdi, bdo_valid}, 3'b110);
      end
      for (int c = 0; c < 5; c++) begin
        step(); bdi_valid = 0; tag_match = 0; msg_auth_ready = 0; #1;
        chk("auth_hold", {msg_auth_valid, msg_auth}, {1'b1, exp_auth});
      end
      step(); msg_auth_ready = 1; #1;
      chk("auth_accept", {msg_auth_valid, msg_auth}, {1'b1, exp_auth});
    end
    step(); bdo_ready = 0; msg_auth_ready = 0; #1;
    chk("back_idle", {bdo_valid, msg_auth_valid, perm_start}, 0);
  endtask

  initial begin
    #12;
    chk_reset();
    step(); rst_n = 1;

    // Encrypt, full 16-byte block
    load_key();
    load_npub(0, 0, 0);
    absorb(4'b0100, 4, 12'h924, 1, 0);
    out_data(4, 16'hFFFF);
    tag_phase(0, -1, 0);

    // Encrypt, 6-byte partial block
    load_npub(1, 0, 0);
    absorb(4'b0100, 2, 12'h014, 1, 1);
    out_data(2, 16'h00CF);
    tag_phase(0, -1, 0);

    // Decrypt with AD block, good tag
    load_npub(1, 1, 0);
    absorb(4'b0001, 1, 12'h004, 0, 1);
    absorb(4'b0100, 4, 12'h924, 1, 0);
    out_data(4, 16'hFFFF);
    tag_phase(1, -1, 1);

    // Decrypt, tag mismatch on word 2
    load_npub(1, 1, 0);
    absorb(4'b0100, 4, 12'h924, 1, 0);
    out_data(4, 16'hFFFF);
    tag_phase(1, 2, 0);

    // Reset while stalled in OUT
    load_npub(1, 0, 0);
    absorb(4'b0100, 1, 12'h004, 1, 1);
    step(); bdo_ready = 0; #1;
    chk("pre_rst_valid", bdo_valid, 1);
    #1 rst_n = 0;
    #1 chk_reset();
    step(); rst_n = 1;

    // Restart, then empty AD and PT
    load_key();
    load_npub(0, 0, 1);
    tag_phase(0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
